// File: rtl/vga_pkg.sv
// Shared constants for the VGA tile renderer: screen geometry, tile codes and palette.
package vga_pkg;

    localparam int HD        = 640;
    localparam int VD        = 480;
    localparam int TILE_LOG2 = 5;

    localparam logic [2:0] FLOOR      = 3'd0;
    localparam logic [2:0] WALL       = 3'd1;
    localparam logic [2:0] PIPE_CLEAN = 3'd2;
    localparam logic [2:0] PIPE_DIRTY = 3'd3;

    localparam logic [23:0] RGB_BLACK      = 24'h000000;
    localparam logic [23:0] RGB_FLOOR      = 24'h202020;
    localparam logic [23:0] RGB_WALL       = 24'h808080;
    localparam logic [23:0] RGB_PIPE_CLEAN = 24'h0000FF;
    localparam logic [23:0] RGB_PIPE_DIRTY = 24'h8B4513;
    localparam logic [23:0] RGB_RESERVED   = 24'hFF00FF;

    // The robot body occupies the central 16x16 pixels of its 32x32 tile.
    function automatic logic in_sprite(input logic [TILE_LOG2-1:0] off);
        return (off >= 5'd8) && (off <= 5'd23);
    endfunction

endpackage

// File: rtl/tile_color_lut.sv
// Combinational palette lookup from a 3-bit tile code to a 24-bit {R,G,B} colour.
module tile_color_lut
    import vga_pkg::*;
(
    input  logic [2:0]  tile,
    output logic [23:0] rgb
);

    always_comb begin
        rgb = RGB_RESERVED;
        case (tile)
            FLOOR:      rgb = RGB_FLOOR;
            WALL:       rgb = RGB_WALL;
            PIPE_CLEAN: rgb = RGB_PIPE_CLEAN;
            PIPE_DIRTY: rgb = RGB_PIPE_DIRTY;
            default:    rgb = RGB_RESERVED;
        endcase
    end

endmodule

// File: rtl/vga_tile_renderer.sv
// Three-stage pixel-colour pipeline: map address, tile fetch plus robot test, then RGB/sync output.
module vga_tile_renderer
    import vga_pkg::*;
#(
    parameter int          MAP_COLS  = 20,
    parameter int          MAP_ROWS  = 15,
    parameter int          ADDR_W    = 9,
    parameter logic [23:0] ROBOT_RGB = 24'hFFFF00
) (
    input  logic              clock_50,
    input  logic              reset_key,
    input  logic              clock_25,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              video_on,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic [4:0]        robot_col,
    input  logic [3:0]        robot_row,
    output logic [ADDR_W-1:0] map_addr,
    input  logic [2:0]        map_data,
    output logic              frame_tick,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs
);

    logic [4:0]        tile_col;
    logic [3:0]        tile_row;
    logic [ADDR_W-1:0] row_ext;
    logic [ADDR_W-1:0] addr_next;
    logic              frame_latch;

    logic [4:0] lat_col;
    logic [3:0] lat_row;
    logic       robot_in_grid;

    logic       s0_valid, s0_video, s0_hs, s0_vs;
    logic [4:0] s0_col, s0_xoff, s0_yoff;
    logic [3:0] s0_row;

    logic       s1_valid, s1_video, s1_hs, s1_vs, s1_hit, s1_border;
    logic [2:0] s1_tile;

    logic       hit_next;
    logic [23:0] lut_rgb;
    logic [23:0] rgb_next;

    assign tile_col    = pixel_x[9:TILE_LOG2];
    assign tile_row    = pixel_y[8:TILE_LOG2];
    // row*20 without a multiplier: row*16 + row*4.
    assign row_ext     = ADDR_W'(tile_row);
    assign addr_next   = (row_ext << 4) + (row_ext << 2) + ADDR_W'(tile_col);
    assign frame_latch = (pixel_x == 10'd0) && (pixel_y == 10'(VD));

    assign robot_in_grid = (lat_col < 5'(MAP_COLS)) && (lat_row < 4'(MAP_ROWS));
    assign hit_next = s0_video && robot_in_grid && (s0_col == lat_col) && (s0_row == lat_row)
                      && in_sprite(s0_xoff) && in_sprite(s0_yoff);

    // Robot position is only sampled during vertical blanking so a frame never tears.
    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            lat_col    <= 5'd31;
            lat_row    <= 4'd15;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= clock_25 && frame_latch;
            if (clock_25 && frame_latch) begin
                lat_col <= robot_col;
                lat_row <= robot_row;
            end
        end
    end

    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            map_addr <= '0;
            s0_valid <= 1'b0;
            s0_video <= 1'b0;
            s0_hs    <= 1'b1;
            s0_vs    <= 1'b1;
            s0_col   <= '0;
            s0_row   <= '0;
            s0_xoff  <= '0;
            s0_yoff  <= '0;
        end else if (clock_25) begin
            if (video_on) begin
                map_addr <= addr_next;
            end
            s0_valid <= 1'b1;
            s0_video <= video_on;
            s0_hs    <= hs_in;
            s0_vs    <= vs_in;
            s0_col   <= tile_col;
            s0_row   <= tile_row;
            s0_xoff  <= pixel_x[TILE_LOG2-1:0];
            s0_yoff  <= pixel_y[TILE_LOG2-1:0];
        end
    end

    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            s1_valid  <= 1'b0;
            s1_video  <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
            s1_tile   <= '0;
            s1_hit    <= 1'b0;
            s1_border <= 1'b0;
        end else if (clock_25) begin
            s1_valid  <= s0_valid;
            s1_video  <= s0_video;
            s1_hs     <= s0_hs;
            s1_vs     <= s0_vs;
            s1_tile   <= map_data;
            s1_hit    <= hit_next;
            s1_border <= (s0_xoff == 5'd0) || (s0_yoff == 5'd0);
        end
    end

    tile_color_lut u_lut (
        .tile (s1_tile),
        .rgb  (lut_rgb)
    );

    // Blanking beats the robot, which beats grid lines, which beat the tile palette.
    always_comb begin
        rgb_next = RGB_BLACK;
        if (!s1_valid || !s1_video) begin
            rgb_next = RGB_BLACK;
        end else if (s1_hit) begin
            rgb_next = ROBOT_RGB;
        end else if (s1_border) begin
            rgb_next = RGB_BLACK;
        end else begin
            rgb_next = lut_rgb;
        end
    end

    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            vga_r  <= 8'd0;
            vga_g  <= 8'd0;
            vga_b  <= 8'd0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
        end else if (clock_25) begin
            {vga_r, vga_g, vga_b} <= rgb_next;
            vga_hs <= s1_hs;
            vga_vs <= s1_vs;
        end
    end

endmodule
